// File: rtl/regfile_pkg.sv
// Shared types, default parameters and helpers for the regfile_sb register file.
package regfile_pkg;

  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;
  localparam int RF_NREAD = 2;

  function automatic int rf_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: destinations are reserved at decode and released at writeback.
// Build option REGFILE_BYPASS_EN makes the per-port lookup see a same-cycle write.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  parameter int NREAD = RF_NREAD,
  localparam int AW   = rf_aw(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic                rsv,
  input  logic [AW-1:0]       rsv_addr,
  input  logic [NREAD*AW-1:0] raddr,
  output logic [NREAD-1:0]    rbusy
);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;

  // The set is applied after the clear: a reservation in the same cycle as a
  // write to that entry belongs to a younger instruction and must stick.
  always_comb begin
    busy_next = busy;
    if (run) begin
      if (we)  busy_next[waddr]    = 1'b0;
      if (rsv) busy_next[rsv_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  always_comb begin
    rbusy = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (run) begin
        rbusy[i] = busy[raddr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        if (we && (waddr != '0) && (raddr[i*AW +: AW] == waddr))
          rbusy[i] = rsv && (rsv_addr == waddr);
`endif
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with busy scoreboard and post-reset clear sequencer.
// Build option REGFILE_BYPASS_EN selects write-first reads; default is read-old.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH,
  parameter int NREAD = RF_NREAD,
  localparam int AW   = rf_aw(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*WIDTH-1:0] rdata,
  output logic [NREAD-1:0]       rbusy,
  input  logic                   rsv,
  input  logic [AW-1:0]          rsvAddr,
  output logic                   ready,
  output rf_state_t              state
);

  logic [WIDTH-1:0] mem [DEPTH];
  rf_state_t        state_next;
  logic [AW-1:0]    clr_idx;
  logic [AW-1:0]    clr_idx_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RF_CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    if (state == RF_CLEAR) begin
      clr_idx_next = clr_idx + 1'b1;
      if (clr_idx == AW'(DEPTH - 1)) state_next = RF_RUN;
    end
  end

  assign ready = (state == RF_RUN);

  // Entry 0 is only touched by the clear sweep; reads of it are forced to zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == RF_CLEAR)
        mem[clr_idx] <= '0;
      else if (we && (waddr != '0))
        mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (ready && (raddr[i*AW +: AW] != '0))
        rdata[i*WIDTH +: WIDTH] = mem[raddr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      if (ready && we && (waddr != '0) && (raddr[i*AW +: AW] == waddr))
        rdata[i*WIDTH +: WIDTH] = wdata;
`endif
    end
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .NREAD (NREAD)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .run      (ready),
    .we       (we),
    .waddr    (waddr),
    .rsv      (rsv),
    .rsv_addr (rsvAddr),
    .raddr    (raddr),
    .rbusy    (rbusy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: driver pushes expected reads/ready into queues, monitor checks on negedge.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;
  localparam int W     = 43;  // {addr[7:0], port[1:0], busy, data[31:0]}
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clk;
  logic                   reset;
  logic                   we;
  logic [AW-1:0]          waddr;
  logic [WIDTH-1:0]       wdata;
  logic [NREAD*AW-1:0]    raddr;
  logic [NREAD*WIDTH-1:0] rdata;
  logic [NREAD-1:0]       rbusy;
  logic                   rsv;
  logic [AW-1:0]          rsv_addr;
  logic                   ready;
  rf_state_t              dut_state;

  regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREAD(NREAD)) dut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr   (raddr),
    .rdata   (rdata),
    .rbusy   (rbusy),
    .rsv     (rsv),
    .rsvAddr (rsv_addr),
    .ready   (ready),
    .state   (dut_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic         rdy_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  logic [W-1:0]     m_e;
  logic             m_r;
  int               m_port;
  logic [WIDTH-1:0] m_got_d;
  logic             m_got_b;

  always @(negedge clk) begin
    while (rdy_q.size() > 0) begin
      m_r = rdy_q.pop_front();
      n_checks++;
      if (ready !== m_r) begin
        n_fail++;
        $display("FAIL ready got %b want %b at %0t", ready, m_r, $time);
      end
    end
    while (exp_q.size() > 0) begin
      m_e     = exp_q.pop_front();
      m_port  = int'(m_e[34:33]);
      m_got_d = rdata[m_port*WIDTH +: WIDTH];
      m_got_b = rbusy[m_port];
      n_checks++;
      if (m_got_d !== m_e[31:0]) begin
        n_fail++;
        $display("FAIL rdata port%0d addr%0d got %h want %h at %0t",
                 m_port, m_e[42:35], m_got_d, m_e[31:0], $time);
      end
      n_checks++;
      if (m_got_b !== m_e[32]) begin
        n_fail++;
        $display("FAIL rbusy port%0d addr%0d got %b want %b at %0t",
                 m_port, m_e[42:35], m_got_b, m_e[32], $time);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_rd(input int port, input int addr, input logic [WIDTH-1:0] d, input logic b);
    logic [7:0] a8;
    logic [1:0] p2;
    a8 = addr[7:0];
    p2 = port[1:0];
    raddr[port*AW +: AW] = addr[AW-1:0];
    exp_q.push_back({a8, p2, b, d});
  endtask

  task automatic exp_ready(input logic r);
    rdy_q.push_back(r);
  endtask

  task automatic drive(input logic w, input int wa, input logic [WIDTH-1:0] wd,
                       input logic r, input int ra);
    we       = w;
    waddr    = wa[AW-1:0];
    wdata    = wd;
    rsv      = r;
    rsv_addr = ra[AW-1:0];
  endtask

  initial begin
    reset = 1'b1;
    raddr = '0;
    drive(1'b0, 0, '0, 1'b0, 0);

    // reset state
    step();
    step();
    exp_ready(1'b0);
    exp_rd(0, 0, 32'h0, 1'b0);
    exp_rd(1, 3, 32'h0, 1'b0);
    step();

    // clear sequence; writes and reservations must be ignored
    reset = 1'b0;
    drive(1'b1, 5, 32'hDEAD, 1'b1, 6);
    for (int k = 1; k <= DEPTH; k++) begin
      step();
      if (k == DEPTH) drive(1'b0, 0, '0, 1'b0, 0);
      exp_ready(k == DEPTH);
      if (k == 1 || k == DEPTH / 2) begin
        exp_rd(0, 5, 32'h0, 1'b0);
        exp_rd(1, 6, 32'h0, 1'b0);
      end
    end
    step();
    exp_rd(0, 5, 32'h0, 1'b0);
    exp_rd(1, 6, 32'h0, 1'b0);

    // write then read from both ports; write to entry 0 discarded
    drive(1'b1, 3, 32'h1234_5678, 1'b0, 0);
    step();
    drive(1'b1, 0, 32'hFFFF_FFFF, 1'b0, 0);
    exp_rd(0, 3, 32'h1234_5678, 1'b0);
    exp_rd(1, 3, 32'h1234_5678, 1'b0);
    step();
    drive(1'b0, 0, '0, 1'b0, 0);
    exp_rd(0, 0, 32'h0, 1'b0);
    exp_rd(1, 0, 32'h0, 1'b0);
    step();

    // reserve / release / reserve entry 0
    drive(1'b0, 0, '0, 1'b1, 7);
    step();
    drive(1'b1, 7, 32'hA5, 1'b0, 0);
    exp_rd(0, 7, 32'h0, 1'b1);
    step();
    drive(1'b0, 0, '0, 1'b1, 0);
    exp_rd(0, 7, 32'hA5, 1'b0);
    step();
    drive(1'b0, 0, '0, 1'b0, 0);
    exp_rd(1, 0, 32'h0, 1'b0);
    step();

    // same-cycle write + reserve to one entry: younger reservation wins
    drive(1'b1, 9, 32'h55, 1'b1, 9);
    step();
    drive(1'b1, 4, 32'h11, 1'b1, 4);
    exp_rd(0, 9, 32'h55, 1'b1);
    exp_rd(1, 9, 32'h55, 1'b1);
    step();

    // same-cycle read of an entry being written
    drive(1'b1, 4, 32'h77, 1'b0, 0);
    exp_rd(0, 4, BYP ? 32'h77 : 32'h11, BYP ? 1'b0 : 1'b1);
    exp_rd(1, 9, 32'h55, 1'b1);
    step();
    drive(1'b1, 10, 32'h99, 1'b1, 10);
    exp_rd(0, 4, 32'h77, 1'b0);
    exp_rd(1, 10, BYP ? 32'h99 : 32'h0, BYP ? 1'b1 : 1'b0);
    step();
    drive(1'b0, 0, '0, 1'b0, 0);
    exp_rd(0, 10, 32'h99, 1'b1);
    exp_rd(1, 4, 32'h77, 1'b0);
    step();

    // reset mid-run: data and busy bits must be wiped by a full clear
    reset = 1'b1;
    exp_ready(1'b1);
    exp_rd(0, 9, 32'h55, 1'b1);
    exp_rd(1, 3, 32'h1234_5678, 1'b0);
    step();
    exp_ready(1'b0);
    exp_rd(0, 9, 32'h0, 1'b0);
    exp_rd(1, 3, 32'h0, 1'b0);
    step();
    reset = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      step();
      exp_ready(k == DEPTH);
    end
    for (int a = 0; a < DEPTH; a += 2) begin
      exp_rd(0, a, 32'h0, 1'b0);
      exp_rd(1, a + 1, 32'h0, 1'b0);
      step();
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0 || rdy_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending %0d want 0", exp_q.size() + rdy_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
